// File: rtl/itrx_amba3_apb_mstr.sv
// APB3 requester: valid/ready command stream in, SETUP/ACCESS transfers out, valid/ready response back.
// Optional access wait-state timeout is compiled in with `define ITRX_APB3_MSTR_TIMEOUT_EN.

package itrx_amba3_apb_pkg;
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } te_pwrite;
endpackage

module itrx_amba3_apb_mstr
    import itrx_amba3_apb_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned TO_CYC = 256
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  te_pwrite      cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic          psel,
    output logic          penable,
    output te_pwrite      pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    te_pwrite      pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          to_hit_c;

`ifdef ITRX_APB3_MSTR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TO_CYC);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts ACCESS wait states; SETUP is the only way into ACCESS, so clear there.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_SETUP) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_ACCESS) && !pready) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign to_hit_c = (state_q == S_ACCESS) && !pready
                      && (wait_cnt_q == CNT_W'(TO_CYC - 1));
`else
    // No abort path; TO_CYC is always >= 2 so this is a constant 0.
    assign to_hit_c = (TO_CYC == 0);
`endif

    assign cmd_ready = (state_q == S_IDLE);

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_valid) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (pready || to_hit_c) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output next values; bus strobes and rsp_valid follow the state being entered.
    always_comb begin
        psel_d        = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d     = (state_d == S_ACCESS);
        rsp_valid_d   = (state_d == S_RESP);
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if ((state_q == S_IDLE) && cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = (cmd_write == WRITE) ? cmd_wdata : '0;
        end

        if (state_q == S_ACCESS) begin
            if (pready) begin
                rsp_rdata_d   = (pwrite_q == READ) ? prdata : '0;
                rsp_err_d     = pslverr;
                rsp_timeout_d = 1'b0;
            end else if (to_hit_c) begin
                rsp_rdata_d   = '0;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= READ;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_itrx_amba3_apb_mstr.sv
// Directed bench for itrx_amba3_apb_mstr; cycle numbers count from the command-accept cycle (0).
// Timeout scenario follows `ITRX_APB3_MSTR_TIMEOUT_EN in the same way as the design.

module tb_itrx_amba3_apb_mstr;
    import itrx_amba3_apb_pkg::*;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned TO_CYC = 8;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    te_pwrite      cmd_write = READ;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    te_pwrite      pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    itrx_amba3_apb_mstr #(
        .AW     (AW),
        .DW     (DW),
        .TO_CYC (TO_CYC)
    ) u_dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send(input te_pwrite w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int          acc_cyc  [3];
    int          idx;
    int          rsp_seen;

    initial begin
        b2b_addr[0] = 32'h40; b2b_addr[1] = 32'h44; b2b_addr[2] = 32'h48;
        b2b_data[0] = 32'hA0; b2b_data[1] = 32'hA1; b2b_data[2] = 32'hA2;
        acc_cyc[0] = -1; acc_cyc[1] = -1; acc_cyc[2] = -1;

        // Reset values, and no accept while held in reset
        #1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, READ);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        send(WRITE, 32'h99, 32'h99);
        tick(); tick();
        check("rst_no_accept_psel", psel, 0);
        check("rst_no_accept_paddr", paddr, 0);
        cmd_valid = 1'b0;
        presetn   = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_psel", psel, 0);

        // Zero-wait write
        send(WRITE, 32'h10, 32'hDEADBEEF);
        pready = 1'b1;
        check("w0_c0_cmd_ready", cmd_ready, 1);
        tick(); cmd_valid = 1'b0;
        check("w0_c1_psel", psel, 1);
        check("w0_c1_penable", penable, 0);
        check("w0_c1_pwrite", pwrite, WRITE);
        check("w0_c1_paddr", paddr, 32'h10);
        check("w0_c1_pwdata", pwdata, 32'hDEADBEEF);
        check("w0_c1_cmd_ready", cmd_ready, 0);
        tick();
        check("w0_c2_psel", psel, 1);
        check("w0_c2_penable", penable, 1);
        check("w0_c2_pwdata", pwdata, 32'hDEADBEEF);
        check("w0_c2_rsp_valid", rsp_valid, 0);
        tick();
        check("w0_c3_rsp_valid", rsp_valid, 1);
        check("w0_c3_rsp_err", rsp_err, 0);
        check("w0_c3_rsp_rdata", rsp_rdata, 0);
        check("w0_c3_rsp_timeout", rsp_timeout, 0);
        check("w0_c3_psel", psel, 0);
        check("w0_c3_penable", penable, 0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        check("w0_c4_rsp_valid", rsp_valid, 0);
        check("w0_c4_cmd_ready", cmd_ready, 1);

        // Read with three wait states
        send(READ, 32'h20, 32'hAAAA5555);
        pready = 1'b0;
        prdata = 32'hFFFFFFFF;
        tick(); cmd_valid = 1'b0;
        check("rd_c1_pwrite", pwrite, READ);
        check("rd_c1_pwdata", pwdata, 0);
        for (int c = 1; c <= 5; c++) begin
            check("rd_psel", psel, 1);
            check("rd_paddr", paddr, 32'h20);
            check("rd_penable", penable, (c >= 2) ? 32'd1 : 32'd0);
            check("rd_rsp_valid_early", rsp_valid, 0);
            if (c == 5) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
            tick();
        end
        prdata = 32'h0;
        check("rd_c6_rsp_valid", rsp_valid, 1);
        check("rd_c6_rsp_rdata", rsp_rdata, 32'h12345678);
        check("rd_c6_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        check("rd_c7_rsp_valid", rsp_valid, 0);

        // Slave error with response backpressure
        send(READ, 32'h30, 32'h0);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFEF00D;
        tick(); cmd_valid = 1'b0;
        tick();
        tick();
        pslverr = 1'b0;
        prdata  = 32'h0;
        for (int k = 0; k < 5; k++) begin
            check("err_rsp_valid", rsp_valid, 1);
            check("err_rsp_err", rsp_err, 1);
            check("err_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
            check("err_psel", psel, 0);
            check("err_cmd_ready", cmd_ready, 0);
            tick();
        end
        check("err_hold_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        check("err_done_rsp_valid", rsp_valid, 0);
        check("err_done_cmd_ready", cmd_ready, 1);

        // Back-to-back commands, cmd_valid held high and rsp_ready high
        idx = 0;
        send(WRITE, b2b_addr[0], b2b_data[0]);
        for (int c = 0; c < 12; c++) begin
            check("b2b_cmd_ready", cmd_ready, (c % 4 == 0) ? 32'd1 : 32'd0);
            check("b2b_psel", psel, ((c % 4 == 1) || (c % 4 == 2)) ? 32'd1 : 32'd0);
            if (c % 4 == 1) begin
                check("b2b_paddr", paddr, b2b_addr[c / 4]);
                check("b2b_pwdata", pwdata, b2b_data[c / 4]);
            end
            if (cmd_valid && cmd_ready && idx < 3) begin
                acc_cyc[idx] = c;
                idx++;
            end
            tick();
            if (idx < 3) send(WRITE, b2b_addr[idx], b2b_data[idx]);
            else cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        check("b2b_count", idx, 3);
        check("b2b_acc0", acc_cyc[0], 0);
        check("b2b_acc1", acc_cyc[1], 4);
        check("b2b_acc2", acc_cyc[2], 8);

        // Access timeout with pready stuck low
        send(READ, 32'h50, 32'h0);
        pready = 1'b0;
        prdata = 32'h5A5A5A5A;
        tick(); cmd_valid = 1'b0;
`ifdef ITRX_APB3_MSTR_TIMEOUT_EN
        for (int c = 1; c <= 9; c++) begin
            check("to_rsp_valid_early", rsp_valid, 0);
            check("to_psel", psel, 1);
            tick();
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel_drop", psel, 0);
        check("to_penable_drop", penable, 0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        check("to_done_cmd_ready", cmd_ready, 1);
`else
        rsp_seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (rsp_valid) rsp_seen++;
            tick();
        end
        check("noto_rsp_seen", rsp_seen, 0);
        check("noto_penable", penable, 1);
        check("noto_rsp_timeout", rsp_timeout, 0);
        presetn = 1'b0;
        #1;
        check("noto_rst_psel", psel, 0);
        tick();
        presetn = 1'b1;
        tick();
        check("noto_rst_cmd_ready", cmd_ready, 1);
`endif

        // Reset mid-ACCESS, then a fresh transfer
        send(WRITE, 32'h60, 32'h11112222);
        pready = 1'b0;
        tick(); cmd_valid = 1'b0;
        tick();
        tick();
        check("mrst_penable_before", penable, 1);
        presetn = 1'b0;
        #1;
        check("mrst_psel", psel, 0);
        check("mrst_penable", penable, 0);
        check("mrst_paddr", paddr, 0);
        check("mrst_pwdata", pwdata, 0);
        check("mrst_cmd_ready", cmd_ready, 1);
        pready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mrst_hold_rsp_valid", rsp_valid, 0);
            check("mrst_hold_psel", psel, 0);
        end
        presetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mrst_rel_rsp_valid", rsp_valid, 0);
            check("mrst_rel_cmd_ready", cmd_ready, 1);
        end
        send(READ, 32'h70, 32'h0);
        prdata = 32'h0BADCAFE;
        tick(); cmd_valid = 1'b0;
        check("new_c1_psel", psel, 1);
        check("new_c1_paddr", paddr, 32'h70);
        tick();
        check("new_c2_penable", penable, 1);
        tick();
        check("new_c3_rsp_valid", rsp_valid, 1);
        check("new_c3_rsp_rdata", rsp_rdata, 32'h0BADCAFE);
        check("new_c3_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        check("new_c4_cmd_ready", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
